issue_sched_12x4: RTL and testbench

Issue-queue scheduler for the out-of-order back end. It holds up to 12 dispatched micro-ops of 160 bits each and tracks per-slot operand readiness. Each cycle it selects up to 4 ready entries, lowest slot index first, and presents them on four launch lanes. Issued slots are freed at the clock edge. The block owns the slot storage and sequencing that sit in front of the 12-to-4 launch select.

---
 rtl/issue_sched_12x4.sv | 174 +++++++++++++++++
 tb/tb_issue_sched_12x4.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_sched_12x4.sv
// ============================================================================
//  Module   : issue_sched_12x4
//  Purpose  : 12-entry issue queue for the out-of-order back end. Each entry
//             tracks valid/ready per slot. Up to four ready entries, lowest
//             slot first, are presented on the launch lanes each cycle.
//  Options  : IQ_PERF_CNT_EN adds the perf_issued / perf_full_cyc counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_sched_12x4 #(
    parameter int DATA_W = 160,
    parameter int DEPTH  = 12,
    parameter int LANES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    input  logic                 dispatch_rdy,
    input  logic [DATA_W-1:0]    dispatch_data,
    output logic                 dispatch_ready,
    output logic [3:0]           alloc_idx,
    input  logic [DEPTH-1:0]     wakeup_vec,
    input  logic                 issue_en,
    output logic [DATA_W-1:0]    lunch_data0,
    output logic [DATA_W-1:0]    lunch_data1,
    output logic [DATA_W-1:0]    lunch_data2,
    output logic [DATA_W-1:0]    lunch_data3,
    output logic [LANES-1:0]     o_vaild,
    output logic [4*LANES-1:0]   issue_idx,
    output logic [3:0]           occupancy
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_full_cyc
`endif
);

    localparam logic [3:0] c_FULL = 4'(DEPTH);

    // Slot state
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DATA_W-1:0] r_payload [DEPTH];
    logic [3:0]        r_occ;

    // Select results
    logic [DEPTH-1:0]  w_cand;
    logic [LANES-1:0]  w_lane_vld;
    logic [3:0]        w_lane_idx [LANES];
    logic [2:0]        w_sel_cnt;
    logic [DATA_W-1:0] w_lane_data [LANES];

    // Allocation / issue bookkeeping
    logic [3:0]        w_alloc;
    logic              w_found;
    logic              w_fire;
    logic              w_issue_go;
    logic [DEPTH-1:0]  w_iss_mask;
    logic [2:0]        w_iss_cnt;
    logic [DEPTH-1:0]  w_alloc_oh;
    logic [DEPTH-1:0]  w_wake;

    assign w_cand         = r_valid & r_ready;
    assign dispatch_ready = ~rst & (r_occ != c_FULL);
    assign w_fire         = dispatch_valid & dispatch_ready & ~flush;
    assign w_issue_go     = issue_en & ~flush;
    assign w_wake         = wakeup_vec & r_valid;
    assign w_alloc_oh     = w_fire ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_alloc) : '0;
    assign alloc_idx      = w_alloc;
    assign occupancy      = r_occ;

    // Lowest free slot; value is irrelevant when the queue is full
    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !w_found) begin
                w_alloc = 4'(i);
                w_found = 1'b1;
            end
        end
    end

    // Pick the first LANES candidates in ascending slot order onto lanes 0..
    always_comb begin
        w_sel_cnt  = '0;
        w_lane_vld = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_idx[k] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_cand[i] && (w_sel_cnt < 3'(LANES))) begin
                w_lane_vld[w_sel_cnt[1:0]] = 1'b1;
                w_lane_idx[w_sel_cnt[1:0]] = 4'(i);
                w_sel_cnt                  = w_sel_cnt + 3'd1;
            end
        end
    end

    // Slots shown on valid lanes are retired only when the group is accepted
    always_comb begin
        w_iss_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_lane_vld[k] && w_issue_go) begin
                w_iss_mask[w_lane_idx[k]] = 1'b1;
            end
        end
        w_iss_cnt = w_issue_go ? w_sel_cnt : 3'd0;
    end

    // Lane payload/index drive; idle lanes are forced to zero
    always_comb begin
        issue_idx = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_data[k]     = w_lane_vld[k] ? r_payload[w_lane_idx[k]] : '0;
            issue_idx[4*k +: 4] = w_lane_idx[k];
        end
    end

    assign o_vaild     = w_lane_vld;
    assign lunch_data0 = w_lane_data[0];
    assign lunch_data1 = w_lane_data[1];
    assign lunch_data2 = w_lane_data[2];
    assign lunch_data3 = w_lane_data[3];

    // Valid/ready flags and occupancy; dispatch, wakeup and issue combine freely
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
            r_ready <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= (r_valid & ~w_iss_mask) | w_alloc_oh;
            r_ready <= ((r_ready | w_wake) & ~w_iss_mask & ~w_alloc_oh)
                     | (w_alloc_oh & {DEPTH{dispatch_rdy}});
            r_occ   <= r_occ + 4'(w_fire) - 4'(w_iss_cnt);
        end
    end

    // Payload storage is write-only on dispatch and never cleared
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_payload[w_alloc] <= dispatch_data;
        end
    end

`ifdef IQ_PERF_CNT_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_full;

    // Issued-op and blocked-dispatch counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issued <= '0;
            r_perf_full   <= '0;
        end else begin
            if (w_issue_go) begin
                r_perf_issued <= r_perf_issued + 32'(w_sel_cnt);
            end
            if (dispatch_valid && !dispatch_ready) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
        end
    end

    assign perf_issued   = r_perf_issued;
    assign perf_full_cyc = r_perf_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_sched_12x4.sv
// ============================================================================
//  Module   : tb_issue_sched_12x4
//  Purpose  : Self-checking bench for issue_sched_12x4 (queue model + directed
//             scenarios). Honours IQ_PERF_CNT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_sched_12x4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         dispatch_valid;
    logic         dispatch_rdy;
    logic [159:0] dispatch_data;
    logic         dispatch_ready;
    logic [3:0]   alloc_idx;
    logic [11:0]  wakeup_vec;
    logic         issue_en;
    logic [159:0] lunch_data0, lunch_data1, lunch_data2, lunch_data3;
    logic [3:0]   o_vaild;
    logic [15:0]  issue_idx;
    logic [3:0]   occupancy;
`ifdef IQ_PERF_CNT_EN
    logic [31:0]  perf_issued;
    logic [31:0]  perf_full_cyc;
`endif

    issue_sched_12x4 dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_rdy   (dispatch_rdy),
        .dispatch_data  (dispatch_data),
        .dispatch_ready (dispatch_ready),
        .alloc_idx      (alloc_idx),
        .wakeup_vec     (wakeup_vec),
        .issue_en       (issue_en),
        .lunch_data0    (lunch_data0),
        .lunch_data1    (lunch_data1),
        .lunch_data2    (lunch_data2),
        .lunch_data3    (lunch_data3),
        .o_vaild        (o_vaild),
        .issue_idx      (issue_idx),
        .occupancy      (occupancy)
`ifdef IQ_PERF_CNT_EN
        ,
        .perf_issued    (perf_issued),
        .perf_full_cyc  (perf_full_cyc)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit           m_init = 0;
    bit           m_valid [12];
    bit           m_ready [12];
    logic [159:0] m_data  [12];
    int           e_n;
    int           e_idx [4];
    longint       m_perf_iss = 0;
    longint       m_perf_full = 0;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 12; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < 12; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic void m_select();
        e_n = 0;
        for (int k = 0; k < 4; k++) e_idx[k] = 0;
        for (int i = 0; i < 12; i++)
            if (m_valid[i] && m_ready[i] && e_n < 4) begin
                e_idx[e_n] = i;
                e_n++;
            end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 12; i++) begin
            m_valid[i] = 0;
            m_ready[i] = 0;
        end
    endfunction

    // Advance the model on every rising edge from the inputs present there
    always @(posedge clk) begin
        if (rst) begin
            m_clear();
            m_init      = 1;
            m_perf_iss  = 0;
            m_perf_full = 0;
        end else if (m_init) begin
            int  a;
            bit  full;
            m_select();
            full = (m_count() == 12);
            if (issue_en && !flush) m_perf_iss += e_n;
            if (dispatch_valid && full) m_perf_full++;
            if (flush) m_clear();
            else begin
                a = m_lowest_free();
                for (int i = 0; i < 12; i++)
                    if (wakeup_vec[i] && m_valid[i]) m_ready[i] = 1;
                if (issue_en)
                    for (int k = 0; k < e_n; k++) begin
                        m_valid[e_idx[k]] = 0;
                        m_ready[e_idx[k]] = 0;
                    end
                if (dispatch_valid && !full) begin
                    m_valid[a] = 1;
                    m_ready[a] = dispatch_rdy;
                    m_data[a]  = dispatch_data;
                end
            end
        end
    end

    logic [159:0] ld [4];
    assign ld[0] = lunch_data0;
    assign ld[1] = lunch_data1;
    assign ld[2] = lunch_data2;
    assign ld[3] = lunch_data3;

    // Compare all outputs against the model mid-cycle
    always @(negedge clk) begin
        if (m_init) begin
            bit exp_rdy;
            m_select();
            exp_rdy = !rst && (m_count() != 12);
            check("occupancy", occupancy, m_count());
            check("dispatch_ready", dispatch_ready, exp_rdy);
            if (exp_rdy) check("alloc_idx", alloc_idx, m_lowest_free());
            check("o_vaild", o_vaild, (4'(1) << e_n) - 1);
            for (int k = 0; k < 4; k++) begin
                check("issue_idx", issue_idx[4*k +: 4], (k < e_n) ? e_idx[k] : 0);
                check("lunch_data", ld[k], (k < e_n) ? m_data[e_idx[k]] : 160'd0);
            end
`ifdef IQ_PERF_CNT_EN
            check("perf_issued", perf_issued, 32'(m_perf_iss));
            check("perf_full_cyc", perf_full_cyc, 32'(m_perf_full));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] dval(input int n);
        return {5{32'hD000_0000 + 32'(n)}};
    endfunction

    initial begin
        rst = 1; flush = 0; dispatch_valid = 0; dispatch_rdy = 0;
        dispatch_data = '0; wakeup_vec = '0; issue_en = 0;
        step(); step();
        rst = 0;
        #1;
        check("rst_occ", occupancy, 0);
        check("rst_vaild", o_vaild, 0);
        check("rst_idx", issue_idx, 0);
        check("rst_data0", lunch_data0, 0);
        check("post_rst_dready", dispatch_ready, 1);

        // Three ready ops A/B/C, then issue
        dispatch_valid = 1; dispatch_rdy = 1;
        dispatch_data = dval(100); step();
        dispatch_data = dval(101); step();
        dispatch_data = dval(102); step();
        dispatch_valid = 0; issue_en = 1;
        check("t1_vaild", o_vaild, 4'b0111);
        check("t1_idx", issue_idx, 16'h0210);
        check("t1_dataA", lunch_data0, dval(100));
        check("t1_dataC", lunch_data2, dval(102));
        step();
        issue_en = 0;
        check("t1_occ", occupancy, 0);

        // Fill with unready ops
        dispatch_valid = 1; dispatch_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            dispatch_data = dval(i);
            step();
        end
        dispatch_valid = 0;
        check("full_dready", dispatch_ready, 0);
        check("full_occ", occupancy, 12);
        wakeup_vec = 12'h0A5; step(); wakeup_vec = 0;
        check("wake_vaild", o_vaild, 4'hF);
        check("wake_idx", issue_idx, 16'h7520);
        issue_en = 1; dispatch_valid = 1; dispatch_data = dval(200);
        check("full_issue_dready", dispatch_ready, 0);
        step();
        issue_en = 0; dispatch_valid = 0;
        check("after_issue_occ", occupancy, 8);
        check("after_issue_dready", dispatch_ready, 1);
        check("after_issue_alloc", alloc_idx, 0);

        // Hold the group for three cycles
        wakeup_vec = 12'h00A; step(); wakeup_vec = 0;
        for (int c = 0; c < 3; c++) begin
            check("hold_vaild", o_vaild, 4'b0011);
            check("hold_data0", lunch_data0, dval(1));
            check("hold_data1", lunch_data1, dval(3));
            check("hold_occ", occupancy, 8);
            step();
        end
        issue_en = 1; step(); issue_en = 0;
        check("hold_issue_occ", occupancy, 6);

        // Flush beats concurrent dispatch and wakeup
        flush = 1; dispatch_valid = 1; dispatch_rdy = 1; wakeup_vec = 12'hFFF;
        step();
        flush = 0; dispatch_valid = 0; wakeup_vec = 0;
        check("flush_occ", occupancy, 0);
        check("flush_vaild", o_vaild, 0);
        check("flush_dready", dispatch_ready, 1);

        // Counter scenario: 2 blocked dispatch cycles, 5 issued ops
        rst = 1; step(); rst = 0;
        dispatch_valid = 1; dispatch_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            dispatch_data = dval(300 + i);
            step();
        end
        step(); step();
        dispatch_valid = 0;
        wakeup_vec = 12'h01F; step(); wakeup_vec = 0;
        issue_en = 1; step(); step(); issue_en = 0;
        check("perf_occ", occupancy, 7);
`ifdef IQ_PERF_CNT_EN
        check("perf_issued_lit", perf_issued, 5);
        check("perf_full_lit", perf_full_cyc, 2);
`endif

        // Mixed deterministic traffic, including a mid-run reset
        for (int c = 0; c < 300; c++) begin
            rst            = (c == 150);
            flush          = (c % 53 == 52);
            dispatch_valid = (c % 3) != 2;
            dispatch_rdy   = c[0];
            dispatch_data  = {5{32'(c) * 32'h0101_0101 + 32'h55}};
            wakeup_vec     = 12'((c * 37) ^ (c >> 1));
            issue_en       = (c % 5) != 0;
            step();
        end
        rst = 0; flush = 0; dispatch_valid = 0; issue_en = 0; wakeup_vec = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
